alu_seq: RTL and testbench

Parametrised, registered successor of the VeriRISC datapath ALU. It accepts one operation per valid/ready handshake and executes single-cycle ops (PASS/ADD/AND/XOR/PASSB/SUB) in one cycle. Shifts and multiply run as multi-cycle iterative ops. It holds the registered result, zero flag and carry flag until the consumer accepts them. It sits between the register file/accumulator and the writeback stage of the multi-cycle controller.

---
 rtl/alu_seq.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith ops, iterative shifts and
// shift-add multiply. Result, zero and carry flags are held until the consumer accepts.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             a_is_zero,
    output logic             carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSB = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] res_s;
    logic             cry_s;
    logic             load_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic [WIDTH:0]   mstep_s;
    logic [SHW-1:0]   amt_s;

    // Next-state, iteration datapath and output-load decode.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        sout_d    = sout_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        res_s     = {WIDTH{1'b0}};
        cry_s     = 1'b0;
        load_s    = 1'b0;
        sum_s     = {1'b0, in_a} + {1'b0, in_b};
        dif_s     = {1'b0, in_a} - {1'b0, in_b};
        amt_s     = in_b[SHW-1:0];
        // {acc,mq} holds the partial product; mq's LSB selects whether A is added
        mstep_s   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op_code;
                    opa_d  = in_a;
                    acc_d  = {WIDTH{1'b0}};
                    mq_d   = in_b;
                    sout_d = 1'b0;
                    case (op_code)
                        OP_ADD:   begin res_s = sum_s[WIDTH-1:0]; cry_s = sum_s[WIDTH]; load_s = 1'b1; end
                        OP_AND:   begin res_s = in_a & in_b; load_s = 1'b1; end
                        OP_XOR:   begin res_s = in_a ^ in_b; load_s = 1'b1; end
                        OP_PASSB: begin res_s = in_b; load_s = 1'b1; end
                        OP_SUB:   begin res_s = dif_s[WIDTH-1:0]; cry_s = dif_s[WIDTH]; load_s = 1'b1; end
                        OP_SHL, OP_SHR: begin
                            if (amt_s == {SHW{1'b0}}) begin
                                res_s  = in_a;
                                load_s = 1'b1;
                            end else begin
                                cnt_d   = {1'b0, amt_s};
                                state_d = S_BUSY;
                            end
                        end
                        OP_MUL: begin
                            cnt_d   = (SHW+1)'(WIDTH);
                            state_d = S_BUSY;
                        end
                        default: begin res_s = in_a; load_s = 1'b1; end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - {{SHW{1'b0}}, 1'b1};
                case (op_q)
                    OP_SHL: begin
                        opa_d  = {opa_q[WIDTH-2:0], 1'b0};
                        sout_d = opa_q[WIDTH-1];
                        res_s  = opa_d;
                        cry_s  = sout_d;
                    end
                    OP_SHR: begin
                        opa_d  = {1'b0, opa_q[WIDTH-1:1]};
                        sout_d = opa_q[0];
                        res_s  = opa_d;
                        cry_s  = sout_d;
                    end
                    OP_MUL: begin
                        acc_d = mstep_s[WIDTH:1];
                        mq_d  = {mstep_s[0], mq_q[WIDTH-1:1]};
                        res_s = mq_d;
                        cry_s = |acc_d;
                    end
                    default: begin
                        cnt_d   = {(SHW+1){1'b0}};
                        state_d = S_IDLE;
                    end
                endcase
                if (cnt_q == {{SHW{1'b0}}, 1'b1}) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_s) begin
            alu_out_d = res_s;
            zero_d    = (res_s == {WIDTH{1'b0}});
            carry_d   = cry_s;
            state_d   = S_DONE;
        end else begin
            alu_out_d = alu_out_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            opa_q     <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            mq_q      <= {WIDTH{1'b0}};
            cnt_q     <= {(SHW+1){1'b0}};
            sout_q    <= 1'b0;
            alu_out_q <= {WIDTH{1'b0}};
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            sout_q    <= sout_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign alu_out   = alu_out_q;
    assign a_is_zero = zero_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, randomized ops against an
// arithmetic reference model, back-pressure and reset during an in-flight multiply.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic [3:0]   op_code;
    logic [W-1:0] in_a, in_b;
    logic         in_ready, out_valid, a_is_zero, carry, busy;
    logic [W-1:0] alu_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .a_is_zero(a_is_zero),
        .carry(carry), .busy(busy)
    );

    // Reference: result/carry by plain integer arithmetic; off = edges after accept until out_valid.
    function automatic void model(input int op, input int a, input int b,
                                  output int r, output int c, output int off);
        int n, p;
        n = b % W; c = 0; off = 0;
        case (op)
            2:  begin p = a + b; r = p % 256; c = (p >= 256) ? 1 : 0; end
            3:  r = a & b;
            4:  r = a ^ b;
            5:  r = b;
            8:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            9:  begin r = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a >> (W - n)) % 2; off = n; end
            10: begin r = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) % 2; off = n; end
            11: begin p = a * b; r = p % 256; c = (p >= 256) ? 1 : 0; off = W; end
            default: r = a;
        endcase
    endfunction

    // Drives one request, scrambles inputs after accept, waits (bounded) for out_valid.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic z,
                         output int off, output int bcnt, output bit to);
        @(negedge clk);
        in_valid = 1'b1; op_code = op; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op_code = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom);
        off = 0; bcnt = 0;
        while (!out_valid && off < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            off++;
        end
        to = !out_valid;
        r = alu_out; c = carry; z = a_is_zero;
    endtask

    task automatic consume(output logic rdy, output logic ov);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        rdy = in_ready; ov = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_code = 4'd0; in_a = 8'd0; in_b = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++; if (alu_out !== 8'h00) $display("FAIL reset_alu_out: got %h want 00", alu_out); else pass_cnt++;
        total_cnt++; if ({a_is_zero, carry, out_valid, busy} !== 4'b0000)
            $display("FAIL reset_flags: got z/c/ov/busy=%b want 0000", {a_is_zero, carry, out_valid, busy}); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [3:0] ops [8] = '{4'd2, 4'd2, 4'd8, 4'd9, 4'd10, 4'd11, 4'd11, 4'd0};
        logic [7:0] as  [8] = '{8'h42, 8'hFF, 8'h05, 8'h81, 8'h81, 8'h0F, 8'h10, 8'h00};
        logic [7:0] bs  [8] = '{8'h86, 8'h01, 8'h07, 8'h03, 8'h00, 8'h11, 8'h10, 8'h5A};
        logic [7:0] ers [8] = '{8'hC8, 8'h00, 8'hFE, 8'h08, 8'h81, 8'hFF, 8'h00, 8'h00};
        logic       ecs [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int         eos [8] = '{0, 0, 0, 3, 0, 8, 8, 0};
        logic [W-1:0] r; logic c, z, rdy, ov; int off, bcnt; bit to;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i], r, c, z, off, bcnt, to);
            total_cnt++; if (to || r !== ers[i] || c !== ecs[i] || z !== (ers[i] == 8'h00))
                $display("FAIL dir%0d_result: got r=%h c=%b z=%b timeout=%0d want r=%h c=%b z=%b",
                         i, r, c, z, to, ers[i], ecs[i], ers[i] == 8'h00); else pass_cnt++;
            total_cnt++; if (off !== eos[i] || bcnt !== eos[i])
                $display("FAIL dir%0d_latency: got off=%0d busy=%0d want %0d", i, off, bcnt, eos[i]); else pass_cnt++;
            consume(rdy, ov);
            total_cnt++; if (rdy !== 1'b1 || ov !== 1'b0)
                $display("FAIL dir%0d_consume: got in_ready=%b out_valid=%b want 1 0", i, rdy, ov); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, a, b; logic [3:0] op; logic c, z, rdy, ov; int off, bcnt, er, ec, eo; bit to;
        for (int i = 0; i < 80; i++) begin
            op = (i % 3 == 0) ? 4'(9 + (i % 9) / 3) : 4'($urandom_range(15, 0));
            a = W'($urandom); b = W'($urandom);
            model(int'(op), int'(a), int'(b), er, ec, eo);
            issue(op, a, b, r, c, z, off, bcnt, to);
            total_cnt++; if (to || int'(r) != er || int'(c) != ec || z !== (er == 0))
                $display("FAIL rnd%0d op%0d a=%h b=%h: got r=%h c=%b z=%b timeout=%0d want r=%h c=%0d z=%b",
                         i, op, a, b, r, c, z, to, er, ec, er == 0); else pass_cnt++;
            total_cnt++; if (off != eo || bcnt != eo)
                $display("FAIL rnd%0d_latency op%0d: got off=%0d busy=%0d want %0d", i, op, off, bcnt, eo); else pass_cnt++;
            consume(rdy, ov);
            total_cnt++; if (rdy !== 1'b1 || ov !== 1'b0)
                $display("FAIL rnd%0d_consume: got in_ready=%b out_valid=%b want 1 0", i, rdy, ov); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] r; logic c, z, rdy, ov; int off, bcnt; bit to;
        issue(4'd4, 8'h42, 8'h86, r, c, z, off, bcnt, to);
        total_cnt++; if (to || r !== 8'hC4 || c !== 1'b0 || z !== 1'b0)
            $display("FAIL bp_xor: got r=%h c=%b z=%b want C4 0 0", r, c, z); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op_code = 4'd2; in_a = W'($urandom); in_b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                             alu_out !== 8'hC4 || carry !== 1'b0 || a_is_zero !== 1'b0)
                $display("FAIL bp_hold%0d: got ov=%b rdy=%b busy=%b r=%h c=%b z=%b want 1 0 0 C4 0 0",
                         i, out_valid, in_ready, busy, alu_out, carry, a_is_zero); else pass_cnt++;
        end
        in_valid = 1'b0;
        consume(rdy, ov);
        total_cnt++; if (rdy !== 1'b1 || ov !== 1'b0 || alu_out !== 8'hC4)
            $display("FAIL bp_release: got rdy=%b ov=%b r=%h want 1 0 C4", rdy, ov, alu_out); else pass_cnt++;
        issue(4'd3, 8'hF0, 8'h3C, r, c, z, off, bcnt, to);
        total_cnt++; if (to || r !== 8'h30 || off != 0)
            $display("FAIL bp_next_and: got r=%h off=%0d want 30 0", r, off); else pass_cnt++;
        consume(rdy, ov);
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r; logic c, z; int off, bcnt; bit to; bit seen;
        @(negedge clk);
        in_valid = 1'b1; op_code = 4'd11; in_a = 8'h0F; in_b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL rst_mul_busy: got %b want 1", busy); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++; if (alu_out !== 8'h00 || carry !== 1'b0 || a_is_zero !== 1'b0 ||
                         out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_mul_state: got r=%h c=%b z=%b ov=%b busy=%b rdy=%b want 00 0 0 0 0 1",
                     alu_out, carry, a_is_zero, out_valid, busy, in_ready); else pass_cnt++;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        total_cnt++; if (seen) $display("FAIL rst_mul_discard: got out_valid=1 want 0"); else pass_cnt++;
        issue(4'd2, 8'h01, 8'h01, r, c, z, off, bcnt, to);
        total_cnt++; if (to || r !== 8'h02 || c !== 1'b0 || z !== 1'b0)
            $display("FAIL rst_after_add: got r=%h c=%b z=%b want 02 0 0", r, c, z); else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
